// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic inter-stage register: state encoding
// and default field widths used to size the payload bus at instantiation sites.
package pipe_stage_elastic_pkg;

  typedef enum logic [1:0] {
    PSE_EMPTY = 2'd0,
    PSE_ONE   = 2'd1,
    PSE_FULL  = 2'd2
  } pse_state_e;

  localparam int DATA_BUS_WIDTH  = 32;
  localparam int ADDR_WIDTH      = 32;
  localparam int REG_IDX_WIDTH   = 5;
  localparam int CTRL_WIDTH      = 4;
  localparam int STALL_CNT_WIDTH = 16;

  // Typical EX->MEM bundle: alu result, store data, destination index, control.
  localparam int EX_MEM_WIDTH = DATA_BUS_WIDTH + DATA_BUS_WIDTH + REG_IDX_WIDTH + CTRL_WIDTH;

  // Number of payloads held for a given state.
  function automatic int unsigned pse_occupancy(input pse_state_e s);
    case (s)
      PSE_ONE:  return 1;
      PSE_FULL: return 2;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_slot.sv
// One payload slot: register with load enable and a synchronous active-low
// clear back to the reset payload.
module pipe_slot
  import pipe_stage_elastic_pkg::*;
#(
  parameter int               WIDTH         = DATA_BUS_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PAYLOAD = '0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q <= RESET_PAYLOAD;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: main + skid slot so in_ready comes straight from
// a flop, with flush-with-squash and a saturating back-pressure counter.
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int               WIDTH         = DATA_BUS_WIDTH,
  parameter int               CNT_WIDTH     = STALL_CNT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PAYLOAD = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [1:0]           fsm_state
);

  // Handshake: a beat moves on a side only in a cycle where both valid and
  // ready are high at the rising edge; valid never waits on ready, and the
  // producer holds data stable while valid is high and ready is low.

  pse_state_e       state_q;
  pse_state_e       state_d;
  logic             in_ready_q;
  logic             accept;
  logic             emit;
  logic             slot_clr_n;
  logic             main_load;
  logic             skid_load;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  assign accept     = in_valid & in_ready_q;
  assign emit       = out_valid & out_ready;
  assign slot_clr_n = rst & ~flush;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_d    = in_data;
    skid_load = 1'b0;
    skid_d    = in_data;
    case (state_q)
      PSE_EMPTY: begin
        if (accept) begin
          main_load = 1'b1;
          state_d   = PSE_ONE;
        end
      end
      PSE_ONE: begin
        if (accept && emit) begin
          main_load = 1'b1;
        end else if (accept) begin
          skid_load = 1'b1;
          state_d   = PSE_FULL;
        end else if (emit) begin
          main_load = 1'b1;
          main_d    = RESET_PAYLOAD;
          state_d   = PSE_EMPTY;
        end
      end
      PSE_FULL: begin
        // Skid advances into main; ready is low here so no accept can occur.
        if (emit) begin
          main_load = 1'b1;
          main_d    = skid_q;
          skid_load = 1'b1;
          skid_d    = RESET_PAYLOAD;
          state_d   = PSE_ONE;
        end
      end
      default: begin
        state_d = PSE_EMPTY;
      end
    endcase
    // Flush squashes everything; the slots are cleared through slot_clr_n.
    if (flush) begin
      state_d = PSE_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= PSE_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != PSE_FULL);
    end
  end

  pipe_slot #(
    .WIDTH         (WIDTH),
    .RESET_PAYLOAD (RESET_PAYLOAD)
  ) u_main_slot (
    .clk   (clk),
    .clr_n (slot_clr_n),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_slot #(
    .WIDTH         (WIDTH),
    .RESET_PAYLOAD (RESET_PAYLOAD)
  ) u_skid_slot (
    .clk   (clk),
    .clr_n (slot_clr_n),
    .load  (skid_load),
    .d     (skid_d),
    .q     (skid_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (cnt_clear) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign out_valid = (state_q != PSE_EMPTY);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed scenarios then random valid/ready
// traffic, all checked against a queue-based occupancy model.
module tb_pipe_stage_elastic;
  import pipe_stage_elastic_pkg::*;

  localparam int               W       = 70;
  localparam int               CW      = 3;
  localparam int               CNT_MAX = (1 << CW) - 1;
  localparam logic [W-1:0]     RP      = 70'h1_5A5A_C3C3_0F0F_1234;

  // clock / reset block
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready = 1'b0;
  logic          cnt_clear = 1'b0;
  logic [CW-1:0] stall_cnt;
  logic [1:0]    fsm_state;

  always #5 clk = ~clk;

  pipe_stage_elastic #(
    .WIDTH         (W),
    .CNT_WIDTH     (CW),
    .RESET_PAYLOAD (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .cnt_clear (cnt_clear),
    .stall_cnt (stall_cnt),
    .fsm_state (fsm_state)
  );

  // scoreboard / reference model
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  bit           m_ready = 1'b1;
  int           m_cnt = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [1:0] exp_state;
    exp_state = (exp_q.size() == 0) ? PSE_EMPTY : (exp_q.size() == 1) ? PSE_ONE : PSE_FULL;
    check("out_valid", W'(out_valid), W'(exp_q.size() > 0));
    check("out_data", out_data, (exp_q.size() > 0) ? exp_q[0] : RP);
    check("in_ready", W'(in_ready), W'(m_ready));
    check("stall_cnt", W'(stall_cnt), W'(m_cnt));
    check("state", W'(fsm_state), W'(exp_state));
  endtask

  // driver: apply one cycle of inputs, advance the model, check after the edge
  task automatic cycle(input bit iv, input logic [W-1:0] id, input bit ordy,
                       input bit fl, input bit cc, input bit rs);
    bit acc;
    bit emt;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    cnt_clear = cc;
    rst       = rs;
    acc = iv && m_ready;
    emt = (exp_q.size() > 0) && ordy;
    if (emt) check("emit_data", out_data, exp_q[0]);
    if (!rs || cc) m_cnt = 0;
    else if ((exp_q.size() > 0) && !ordy && (m_cnt < CNT_MAX)) m_cnt++;
    if (!rs || fl) begin
      exp_q.delete();
    end else begin
      if (emt) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(id);
    end
    m_ready = (exp_q.size() < 2);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // upstream must keep valid and data stable while stalled
  logic         hold_pend = 1'b0;
  logic [W-1:0] hold_data = '0;
  always @(posedge clk) begin
    if (hold_pend) begin
      check("hold_valid", W'(in_valid), W'(1'b1));
      check("hold_data", in_data, hold_data);
    end
    hold_pend <= rst && !flush && in_valid && !in_ready;
    hold_data <= in_data;
  end

  function automatic logic [W-1:0] rand_data();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  initial begin
    bit           iv;
    bit           ordy;
    bit           fl;
    bit           cc;
    bit           rs;
    bit           blocked;
    bit           ready_pre;
    logic [W-1:0] id;
    logic [W-1:0] last_d;

    // reset
    cycle(0, '0, 0, 0, 0, 0);
    cycle(0, '0, 0, 0, 0, 0);
    cycle(0, '0, 0, 0, 0, 1);

    // streaming 1..5 at full throughput, then drain
    for (int i = 1; i <= 5; i++) cycle(1, W'(i), 1, 0, 0, 1);
    cycle(0, '0, 1, 0, 0, 1);
    cycle(0, '0, 1, 0, 0, 1);

    // back-pressure into the skid slot, then release
    cycle(1, W'(8'h0A), 0, 0, 0, 1);
    cycle(1, W'(8'h0B), 0, 0, 0, 1);
    check("skid_full", W'(fsm_state), W'(PSE_FULL));
    check("skid_head", out_data, W'(8'h0A));
    cycle(0, '0, 1, 0, 0, 1);
    check("skid_ready_back", W'(in_ready), W'(1'b1));
    cycle(0, '0, 1, 0, 0, 1);
    cycle(0, '0, 1, 0, 0, 1);

    // flush while FULL and 0xC is offered; 0xC must never appear
    cycle(1, W'(8'h11), 0, 0, 1, 1);
    cycle(1, W'(8'h12), 0, 0, 0, 1);
    cycle(1, W'(8'h0C), 0, 1, 0, 1);
    check("flush_data", out_data, RP);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, 0, 1);

    // reset while ONE, with flush also high; then resume
    cycle(1, W'(8'h0D), 0, 0, 0, 1);
    cycle(0, '0, 0, 0, 0, 1);
    cycle(0, '0, 0, 1, 0, 0);
    check("rst_cnt", W'(stall_cnt), W'(0));
    cycle(1, W'(8'h0E), 1, 0, 0, 1);
    cycle(0, '0, 1, 0, 0, 1);
    cycle(0, '0, 1, 0, 0, 1);

    // counter saturation, clear priority, flush leaves it alone
    cycle(1, W'(8'h21), 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) cycle(0, '0, 0, 0, 0, 1);
    check("cnt_sat", W'(stall_cnt), W'(CNT_MAX));
    cycle(0, '0, 0, 0, 1, 1);
    check("cnt_clear_inc", W'(stall_cnt), W'(0));
    cycle(0, '0, 0, 0, 0, 1);
    cycle(0, '0, 0, 0, 0, 1);
    cycle(0, '0, 1, 0, 0, 1);
    cycle(1, W'(8'h22), 1, 0, 0, 1);
    cycle(0, '0, 1, 1, 0, 1);
    check("cnt_after_flush", W'(stall_cnt), W'(2));

    // random traffic
    blocked = 1'b0;
    last_d  = '0;
    for (int n = 0; n < 10000; n++) begin
      iv   = ($urandom_range(1, 0) == 1);
      id   = rand_data();
      ordy = ($urandom_range(1, 0) == 1);
      fl   = ($urandom_range(99, 0) == 0);
      cc   = ($urandom_range(199, 0) == 0);
      rs   = ($urandom_range(499, 0) != 0);
      if (blocked) begin
        iv = 1'b1;
        id = last_d;
      end
      ready_pre = m_ready;
      cycle(iv, id, ordy, fl, cc, rs);
      blocked = iv && !ready_pre && rs && !fl;
      last_d  = id;
    end
    cycle(0, '0, 1, 0, 0, 1);
    cycle(0, '0, 1, 0, 0, 1);
    cycle(0, '0, 1, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised, elastic successor to the fixed-field stall/flush inter-stage register. It carries one opaque payload bus between two pipeline stages (for example EX->MEM) using a valid/ready handshake. A 2-entry skid buffer lets the upstream ready be fully registered, so there is no combinational ready path across stages. It also adds flush-with-squash and a saturating back-pressure counter for performance monitoring.

Parameters:
WIDTH, 32, payload width in bits (>=1); callers concatenate stage fields into one bus.
CNT_WIDTH, 16, width of the back-pressure cycle counter (>=1).
RESET_PAYLOAD, 0, value driven on out_data after reset/flush and whenever the stage is empty.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
flush  in  1  squash all held entries (exception/eret/branch redirect).
in_valid  in  1  upstream presents a payload.
in_data  in  WIDTH  upstream payload.
in_ready  out  1  stage can accept; registered output.
out_valid  out  1  stage holds a payload for downstream.
out_data  out  WIDTH  head payload (main slot).
out_ready  in  1  downstream accepts this cycle.
cnt_clear  in  1  synchronous clear of stall_cnt.
stall_cnt  out  CNT_WIDTH  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Handshake terms: accept = in_valid & in_ready; emit = out_valid & out_ready.
- Storage is a main slot (drives out_data) and a skid slot. The FSM has 3 states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main slot full, out_valid=1, in_ready=1.
  - FULL: both slots full, out_valid=1, in_ready=0.
- Transitions (absent flush and reset):
  - EMPTY: accept -> main<=in_data, go to ONE; otherwise stay.
  - ONE: accept&emit -> main<=in_data, stay ONE. accept only -> skid<=in_data, go to FULL. emit only -> main<=RESET_PAYLOAD, go to EMPTY. Neither -> hold.
  - FULL: emit -> main<=skid, skid<=RESET_PAYLOAD, go to ONE. No emit -> hold. Accept is impossible because in_ready=0.
- Latency: 1 cycle minimum, from accepted in_data to out_data. Throughput is 1 per cycle while out_ready=1. Ordering is strict FIFO, and no payload is dropped or duplicated.
- in_ready is driven from a flop: the next value is 0 iff the next state is FULL.
- When out_valid=0, out_data is RESET_PAYLOAD, as is skid when it is empty.
- Flush: the next state is EMPTY, both slots become RESET_PAYLOAD and in_ready=1. Any accept or emit in the flush cycle is discarded for the stage's own state. The downstream may still sample the emit in that cycle; squashing it is the downstream's responsibility. Flush has priority over accept and emit.
- Reset (rst=0 at an edge), with priority over flush:
  - State becomes EMPTY, out_valid=0, in_ready=1.
  - out_data and skid become RESET_PAYLOAD; stall_cnt=0.
  - Reset asserted mid-transfer drops both held entries.
- stall_cnt:
  - Increments each cycle with out_valid & ~out_ready and saturates at all-ones.
  - cnt_clear has priority over increment and sets it to 0.
  - Flush does not clear it.
- in_valid may be asserted without waiting for in_ready. The upstream must hold in_data stable while in_valid & ~in_ready; the bench checks this as an assertion.

Decomposition:
- Shared package holds:
  - state encoding constants PSE_EMPTY=2'd0, PSE_ONE=2'd1, PSE_FULL=2'd2;
  - default widths (DATA_BUS_WIDTH, etc.) used to compute WIDTH at instantiation sites.
- One natural sub-module, pipe_slot: a WIDTH-bit register with load enable and a synchronous active-low clear to RESET_PAYLOAD. It is instantiated twice (main and skid).
- FSM, ready flop and counter live in the top module.

Test Plan:
1. Streaming: out_ready=1, in_valid=1 with in_data=1,2,3,4,5 -> out_data 1..5 on consecutive cycles starting 1 cycle after the first accept; in_ready stays 1.
2. Back-pressure and skid: send 0xA, 0xB with out_ready=0.
   - Expected: state FULL, in_ready=0 on the cycle after 0xB, out_data=0xA.
   - Then raise out_ready for 2 cycles -> 0xA, then 0xB, with no loss; in_ready returns to 1 after the first emit.
3. Flush in FULL while in_valid=1 carries 0xC -> next cycle out_valid=0, out_data=RESET_PAYLOAD, in_ready=1, and 0xC is never emitted.
4. Reset mid-operation: drive rst=0 for 1 edge while in ONE, with flush=1 and cnt_clear=0 -> all outputs at reset values and stall_cnt=0; the FSM resumes correctly on the next accept.
5. Counter with CNT_WIDTH=3:
   - Hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt saturates at 7.
   - A cnt_clear pulse -> 0; an increment in the same cycle as cnt_clear -> 0.
   - Flush leaves it unchanged.
6. Random valid/ready at 50% each, 10k cycles, WIDTH=70, compared against a reference queue -> identical order, no drops, in_data stable while stalled.
